// File: rtl/route_compute_if.sv
// Flit-in / flit-out / routing-table signals of one route-compute stage.
// The stage itself connects through "slave"; the surrounding router (or a bench) uses "master".
interface route_compute_if #(
    parameter int ADDR_W = 4,
    parameter int DIR_W  = 3,
    parameter int DATA_W = 32
);
    logic [DATA_W+1:0] in_flit;
    logic              in_valid;
    logic              in_ready;
    logic [ADDR_W-1:0] table_addr;
    logic [DIR_W-1:0]  table_data;
    logic [DATA_W+1:0] out_flit;
    logic              out_valid;
    logic              out_ready;
    logic [DIR_W-1:0]  out_dir;
    logic              busy;
    logic              proto_err;
    logic [7:0]        drop_count;

    modport slave (
        input  in_flit, in_valid, table_data, out_ready,
        output in_ready, table_addr, out_flit, out_valid, out_dir, busy, proto_err, drop_count
    );

    modport master (
        output in_flit, in_valid, table_data, out_ready,
        input  in_ready, table_addr, out_flit, out_valid, out_dir, busy, proto_err, drop_count
    );
endinterface

// File: rtl/route_compute.sv
// Per-input-port route computation: looks up the head's destination in the node's routing
// table, then streams the packet to the switch allocator tagged with that direction.
module route_compute #(
    parameter int ADDR_W = 4,
    parameter int DIR_W  = 3,
    parameter int DATA_W = 32
) (
    input  logic           clk,
    input  logic           reset,
    route_compute_if.slave bus
);
    localparam int FW = DATA_W + 2;
    localparam logic [DIR_W-1:0] DIR_LOCAL = DIR_W'(4);

    typedef enum logic [1:0] {IDLE, LOOKUP, SEND} state_t;

    state_t            r_state, w_next_state;
    logic [FW-1:0]     r_hold;
    logic [FW-1:0]     r_out_flit;
    logic [ADDR_W-1:0] r_table_addr;
    logic [DIR_W-1:0]  r_out_dir;
    logic [7:0]        r_drop_count;
    logic              r_out_valid;
    logic              r_tail_loaded;
    logic              r_proto_err;

    logic [1:0] w_in_type;
    logic       w_in_head;
    logic       w_in_tail;
    logic       w_in_ready;
    logic       w_accept;
    logic       w_depart;
    logic       w_table_bad;

    assign w_in_type   = bus.in_flit[FW-1:DATA_W];
    assign w_in_head   = w_in_type[1];
    assign w_in_tail   = (w_in_type == 2'b01);
    assign w_accept    = bus.in_valid && w_in_ready;
    assign w_depart    = r_out_valid && bus.out_ready;
    assign w_table_bad = (bus.table_data > DIR_LOCAL);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= IDLE;
        else        r_state <= w_next_state;
    end

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        w_next_state = r_state;
        w_in_ready   = 1'b0;
        unique case (r_state)
            IDLE: begin
                w_in_ready = 1'b1;
                if (bus.in_valid && w_in_head) w_next_state = LOOKUP;
            end
            LOOKUP: w_next_state = SEND;
            SEND: begin
                // Once the tail is loaded nothing more is accepted, so this departure ends the packet.
                w_in_ready = !r_tail_loaded && (!r_out_valid || bus.out_ready);
                if (w_depart && r_tail_loaded) w_next_state = IDLE;
            end
            default: w_next_state = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_hold        <= '0;
            r_out_flit    <= '0;
            r_table_addr  <= '0;
            r_out_dir     <= DIR_LOCAL;
            r_drop_count  <= '0;
            r_out_valid   <= 1'b0;
            r_tail_loaded <= 1'b0;
            r_proto_err   <= 1'b0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (w_accept && w_in_head) begin
                        r_hold       <= bus.in_flit;
                        r_table_addr <= bus.in_flit[ADDR_W-1:0];
                    end else if (w_accept) begin
                        r_proto_err <= 1'b1;
                        if (r_drop_count != 8'hFF) r_drop_count <= r_drop_count + 8'd1;
                    end
                end
                LOOKUP: begin
                    r_out_dir     <= w_table_bad ? DIR_LOCAL : bus.table_data;
                    if (w_table_bad) r_proto_err <= 1'b1;
                    r_out_flit    <= r_hold;
                    r_out_valid   <= 1'b1;
                    r_tail_loaded <= (r_hold[FW-1:DATA_W] == 2'b11);
                end
                SEND: begin
                    if (w_accept) begin
                        r_out_valid <= 1'b1;
                        // A stray head inside a packet is demoted to a body on the current route.
                        if (w_in_head) begin
                            r_out_flit  <= {2'b00, bus.in_flit[DATA_W-1:0]};
                            r_proto_err <= 1'b1;
                        end else begin
                            r_out_flit <= bus.in_flit;
                        end
                        if (w_in_tail) r_tail_loaded <= 1'b1;
                    end else if (w_depart) begin
                        r_out_valid   <= 1'b0;
                        r_tail_loaded <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.in_ready   = w_in_ready;
    assign bus.table_addr = r_table_addr;
    assign bus.out_flit   = r_out_flit;
    assign bus.out_valid  = r_out_valid;
    assign bus.out_dir    = r_out_dir;
    assign bus.busy       = (r_state != IDLE);
    assign bus.proto_err  = r_proto_err;
    assign bus.drop_count = r_drop_count;
endmodule

// File: tb/tb_route_compute.sv
// Bench for route_compute at node 5 of a 4x4 mesh; the routing table is an XY-routing model
// and expected flits/directions/counters come from a packet-level reference model.
module tb_route_compute;
    localparam int ADDR_W  = 4;
    localparam int DIR_W   = 3;
    localparam int DATA_W  = 32;
    localparam int FW      = DATA_W + 2;
    localparam int NODE_ID = 5;

    logic clk;
    logic reset;
    bit   bad_table;
    int   n_checks;
    int   n_errors;
    bit   m_proto_err;
    int   m_drops;

    route_compute_if #(.ADDR_W(ADDR_W), .DIR_W(DIR_W), .DATA_W(DATA_W)) bus ();

    route_compute #(.ADDR_W(ADDR_W), .DIR_W(DIR_W), .DATA_W(DATA_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // XY routing in a 4x4 mesh, X first; y grows southward.
    function automatic logic [DIR_W-1:0] xy_route(input int dest);
        int cx, cy, dx, dy;
        cx = NODE_ID % 4; cy = NODE_ID / 4;
        dx = dest % 4;    dy = dest / 4;
        if (dx > cx) return 3'd1;
        if (dx < cx) return 3'd3;
        if (dy > cy) return 3'd2;
        if (dy < cy) return 3'd0;
        return 3'd4;
    endfunction

    assign bus.table_data = bad_table ? 3'd6 : xy_route(int'(bus.table_addr));

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_status();
        check("proto_err", 64'(bus.proto_err), 64'(m_proto_err));
        check("drop_count", 64'(bus.drop_count), 64'(m_drops));
    endtask

    // ready_mode: 0 = always ready, 1 = pattern 1,0,0,1,..., 2 = random.
    task automatic run_packet(input logic [ADDR_W-1:0] dest, input int len, input int ready_mode,
                              input bit gaps, input bit head_mid);
        logic [FW-1:0]    in_q[$];
        logic [FW-1:0]    exp_q[$];
        logic [31:0]      rnd;
        logic [DIR_W-1:0] exp_dir;
        int acc_cyc, first_dep, last_dep;
        bit seen, done;
        rnd = $urandom;
        if (len == 1) in_q.push_back({2'b11, rnd[DATA_W-1:ADDR_W], dest});
        else          in_q.push_back({2'b10, rnd[DATA_W-1:ADDR_W], dest});
        for (int i = 1; i < len; i++) begin
            rnd = $urandom;
            in_q.push_back({(i == len - 1) ? 2'b01 : 2'b00, rnd});
        end
        foreach (in_q[i]) exp_q.push_back(in_q[i]);
        if (head_mid && len >= 3) begin
            in_q[1][FW-1:DATA_W] = 2'b10;
            m_proto_err = 1'b1;
        end
        exp_dir = bad_table ? 3'd4 : xy_route(int'(dest));
        if (bad_table) m_proto_err = 1'b1;
        acc_cyc = -1; first_dep = -1; last_dep = -1; seen = 0; done = 0;

        for (int cyc = 0; cyc < 400 && !done; cyc++) begin
            @(negedge clk);
            case (ready_mode)
                0:       bus.out_ready = 1'b1;
                1:       bus.out_ready = (cyc % 4 == 0) || (cyc % 4 == 3);
                default: bus.out_ready = 1'($urandom_range(0, 1));
            endcase
            if (in_q.size() > 0 && (!gaps || $urandom_range(0, 3) != 0)) begin
                bus.in_valid = 1'b1;
                bus.in_flit  = in_q[0];
            end else begin
                bus.in_valid = 1'b0;
            end
            #1;
            if (bus.out_valid) begin
                if (!seen) begin
                    seen = 1;
                    check("head_latency", 64'(cyc), 64'(acc_cyc + 2));
                    check("table_addr", 64'(bus.table_addr), 64'(dest));
                end
                if (exp_q.size() > 0) check("out_flit", 64'(bus.out_flit), 64'(exp_q[0]));
                else                  check("extra_flit", 64'(bus.out_valid), 64'd0);
                check("out_dir", 64'(bus.out_dir), 64'(exp_dir));
                if (bus.out_ready) begin
                    if (exp_q.size() > 0) exp_q.delete(0);
                    if (first_dep < 0) first_dep = cyc;
                    last_dep = cyc;
                end
            end
            if (bus.in_valid && bus.in_ready) begin
                if (acc_cyc < 0) acc_cyc = cyc;
                in_q.delete(0);
            end
            if (in_q.size() == 0 && exp_q.size() == 0 && last_dep == cyc) done = 1;
        end
        check("packet_complete", 64'(done), 64'd1);
        if (ready_mode == 0 && !gaps) check("throughput", 64'(last_dep - first_dep), 64'(len - 1));
        @(negedge clk);
        bus.in_valid = 1'b0;
        #1;
        check("busy_after_tail", 64'(bus.busy), 64'd0);
        check("in_ready_after_tail", 64'(bus.in_ready), 64'd1);
        check("out_valid_after_tail", 64'(bus.out_valid), 64'd0);
        check_status();
    endtask

    task automatic send_one(input logic [FW-1:0] f);
        int n;
        n = 0;
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_flit  = f;
        #1;
        while (!bus.in_ready && n < 20) begin
            @(negedge clk);
            #1;
            n++;
        end
        check("send_ready", 64'(bus.in_ready), 64'd1);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        n_checks = 0; n_errors = 0; m_proto_err = 0; m_drops = 0; bad_table = 0;
        reset = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_flit   = '0;
        bus.out_ready = 1'b0;
        #12;
        check("rst_out_valid", 64'(bus.out_valid), 64'd0);
        check("rst_out_flit", 64'(bus.out_flit), 64'd0);
        check("rst_out_dir", 64'(bus.out_dir), 64'd4);
        check("rst_table_addr", 64'(bus.table_addr), 64'd0);
        check("rst_busy", 64'(bus.busy), 64'd0);
        check_status();
        @(negedge clk);
        reset = 1'b1;

        run_packet(4'd9, 4, 0, 0, 0);
        run_packet(4'd5, 1, 0, 0, 0);
        run_packet(4'd0, 4, 1, 0, 0);
        run_packet(4'd3, 4, 0, 0, 1);

        send_one({2'b00, 32'hB0D1_0001});
        send_one({2'b01, 32'h7A11_0002});
        m_drops = 2; m_proto_err = 1'b1;
        #1;
        check("drop_busy", 64'(bus.busy), 64'd0);
        check_status();
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_flit  = {2'b00, 32'h0};
        repeat (253) @(posedge clk);
        #1;
        m_drops = 255;
        check("drop_count_255", 64'(bus.drop_count), 64'(m_drops));
        repeat (3) @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        check("drop_count_sat", 64'(bus.drop_count), 64'(m_drops));

        bad_table = 1;
        run_packet(4'd6, 1, 0, 0, 0);
        bad_table = 0;

        for (int p = 0; p < 8; p++)
            run_packet(4'($urandom_range(0, 15)), $urandom_range(1, 5), $urandom_range(0, 2), 1'($urandom_range(0, 1)), 0);

        bus.out_ready = 1'b1;
        send_one({2'b10, 28'h1234567, 4'd9});
        send_one({2'b00, 32'hCAFE_F00D});
        #3;
        reset = 1'b0;
        #1;
        m_proto_err = 0; m_drops = 0;
        check("async_rst_out_valid", 64'(bus.out_valid), 64'd0);
        check("async_rst_out_dir", 64'(bus.out_dir), 64'd4);
        check("async_rst_busy", 64'(bus.busy), 64'd0);
        check("async_rst_table_addr", 64'(bus.table_addr), 64'd0);
        check_status();
        @(negedge clk);
        reset = 1'b1;
        run_packet(4'd15, 3, 0, 0, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
